load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/dm_pkg.sv | 44 ++++
 rtl/load_extend.sv | 38 +++
 rtl/load_unit.sv | 111 +++++++++++
 tb/tb_load_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared data-memory definitions: load/store op encodings, load-unit state
// encoding and the memory depth used by the load path and the data memory.
package dm_pkg;

  localparam int DM_WORDS = 3072;
  localparam int DM_AW    = 12;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LB  = 3'b001,
    LD_LH  = 3'b010,
    LD_LBU = 3'b011,
    LD_LHU = 3'b100
  } ld_op_e;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } st_op_e;

  typedef enum logic [1:0] {
    LU_IDLE = 2'b00,
    LU_READ = 2'b01,
    LU_CAPT = 2'b10,
    LU_RESP = 2'b11
  } lu_state_e;

  // Reserved op, misalignment for its width, or an address past the memory.
  function automatic logic ld_req_err(input logic [31:0] addr, input logic [2:0] op);
    logic bad;
    bad = 1'b0;
    case (op)
      LD_LW:          bad = (addr[1:0] != 2'b00);
      LD_LH, LD_LHU:  bad = addr[0];
      LD_LB, LD_LBU:  bad = 1'b0;
      default:        bad = 1'b1;
    endcase
    if (addr[31:14] != 18'd0) bad = 1'b1;
    if (addr[13:2] >= 12'(DM_WORDS)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Byte/half/word extraction and sign/zero extension of a memory word;
// purely combinational so the pipeline can share it.
module load_extend
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  op,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'b00:   byte_sel = word[7:0];
      2'b01:   byte_sel = word[15:8];
      2'b10:   byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = 32'd0;
    case (op)
      LD_LW:   result = word;
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {24'd0, byte_sel};
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result = {16'd0, half_sel};
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: accepts a load request, reads one word from
// data memory, extracts/extends the result and holds it until consumed.
//
//   state | meaning
//   IDLE  | ready for a request
//   READ  | word-read strobe issued to data memory
//   CAPT  | memory word returned, extracted result registered
//   RESP  | response (data or error) held until rsp_ready
module load_unit
  import dm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_op,
  output logic        mem_rd_en,
  output logic [11:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  lu_state_e   state_q, state_d;
  logic [13:0] addr_q, addr_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] ext_result;

  load_extend u_load_extend (
    .word    (mem_rdata),
    .addr_lo (addr_q[1:0]),
    .op      (op_q),
    .result  (ext_result)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_addr   = 12'd0;
    rsp_valid  = 1'b0;
    rsp_data   = 32'd0;
    rsp_err    = 1'b0;

    case (state_q)
      LU_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d = req_addr[13:0];
          op_d   = req_op;
          if (ld_req_err(req_addr, req_op)) begin
            rsp_data_d = 32'd0;
            rsp_err_d  = 1'b1;
            state_d    = LU_RESP;
          end else begin
            state_d = LU_READ;
          end
        end
      end
      LU_READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_q[13:2];
        state_d   = LU_CAPT;
      end
      LU_CAPT: begin
        // Memory word is valid this cycle; address held for the read path.
        mem_addr   = addr_q[13:2];
        rsp_data_d = ext_result;
        rsp_err_d  = 1'b0;
        state_d    = LU_RESP;
      end
      LU_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = rsp_data_q;
        rsp_err   = rsp_err_q;
        if (rsp_ready) begin
          rsp_data_d = 32'd0;
          rsp_err_d  = 1'b0;
          state_d    = LU_IDLE;
        end
      end
      default: state_d = LU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LU_IDLE;
      addr_q     <= 14'd0;
      op_q       <= 3'd0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: stimulus pushes expected responses, a
// negedge monitor pops and compares them as responses appear.
module tb_load_unit;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_op;
  logic        mem_rd_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  load_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_op    (req_op),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  op;
    logic [31:0] data;
    logic        err;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vv[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rd_seen = 0;
  logic [31:0] mem [DM_WORDS];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns data the cycle after the strobe; garbage otherwise.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  logic        prev_valid = 1'b0;
  logic [31:0] held_data;
  exp_t        cur;

  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_seen++;
      if (exp_q.size() > 0) chk("mem_addr", {20'd0, mem_addr}, {20'd0, exp_q[0].addr[13:2]});
    end
    if (rsp_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got data %h err %b, want no response", rsp_data, rsp_err);
      end else begin
        cur = exp_q.pop_front();
        chk("rsp_data", rsp_data, cur.data);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, cur.err});
        chk("latency", 32'(cyc - cur.acc + 1), cur.err ? 32'd1 : 32'd3);
      end
      held_data = rsp_data;
    end else if (rsp_valid) begin
      chk("rsp_hold", rsp_data, held_data);
    end else begin
      chk("rsp_zero", rsp_data | {31'd0, rsp_err}, 32'd0);
    end
    prev_valid = rsp_valid;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic [2:0] op,
                       input logic [31:0] data, input logic err);
    exp_t e;
    for (int i = 0; i < 20 && !req_ready; i++) step();
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got req_ready 0, want 1");
      return;
    end
    req_valid = 1'b1;
    req_addr  = addr;
    req_op    = op;
    e.addr = addr;
    e.data = data;
    e.err  = err;
    e.acc  = cyc + 1;
    exp_q.push_back(e);
    step();
    // Scramble inputs right after accept; the in-flight load must not notice.
    req_valid = 1'b0;
    req_addr  = 32'h0000_3000;
    req_op    = 3'b110;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (exp_q.size() != 0 || !req_ready); i++) step();
    if (exp_q.size() != 0 || !req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_mem_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
    chk({tag, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 10 && !rsp_valid; i++) step();
    chk("wait_rsp_valid", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic quiet_after_reset(input string tag);
    int rd0;
    rd0 = rd_seen;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid) break;
    end
    chk({tag, "_no_rsp"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_no_rd"}, 32'(rd_seen), 32'(rd0));
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [2:0] o,
                              input logic [31:0] d, input logic e);
    vec_t v;
    v.addr = a;
    v.op   = o;
    v.data = d;
    v.err  = e;
    return v;
  endfunction

  initial begin
    int rd0;
    for (int i = 0; i < DM_WORDS; i++) mem[i] = 32'h0;
    mem[1]    = 32'h8081_7F02;
    mem[2]    = 32'h1234_ABCD;
    mem[3071] = 32'hCAFE_F00D;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    req_op    = 3'd0;
    rsp_ready = 1'b1;
    step(2);
    chk_reset_vals("por");
    reset = 1'b0;
    step();

    vv.push_back(mk(32'h5,    3'b001, 32'h0000_007F, 1'b0));
    vv.push_back(mk(32'h6,    3'b001, 32'hFFFF_FF81, 1'b0));
    vv.push_back(mk(32'h7,    3'b011, 32'h0000_0080, 1'b0));
    vv.push_back(mk(32'h6,    3'b010, 32'hFFFF_8081, 1'b0));
    vv.push_back(mk(32'h6,    3'b100, 32'h0000_8081, 1'b0));
    vv.push_back(mk(32'h4,    3'b000, 32'h8081_7F02, 1'b0));
    vv.push_back(mk(32'h4,    3'b001, 32'h0000_0002, 1'b0));
    vv.push_back(mk(32'h4,    3'b010, 32'h0000_7F02, 1'b0));
    vv.push_back(mk(32'h9,    3'b001, 32'hFFFF_FFAB, 1'b0));
    vv.push_back(mk(32'h9,    3'b011, 32'h0000_00AB, 1'b0));
    vv.push_back(mk(32'h8,    3'b100, 32'h0000_ABCD, 1'b0));
    vv.push_back(mk(32'hA,    3'b010, 32'h0000_1234, 1'b0));
    vv.push_back(mk(32'h2FFC, 3'b000, 32'hCAFE_F00D, 1'b0));
    foreach (vv[i]) begin
      issue(vv[i].addr, vv[i].op, vv[i].data, vv[i].err);
      drain();
    end

    // Back-to-back issue relying on req_ready pacing.
    issue(32'h4, 3'b000, 32'h8081_7F02, 1'b0);
    issue(32'h8, 3'b000, 32'h1234_ABCD, 1'b0);
    drain();

    vv.delete();
    vv.push_back(mk(32'h6,         3'b000, 32'h0, 1'b1));
    vv.push_back(mk(32'h3,         3'b010, 32'h0, 1'b1));
    vv.push_back(mk(32'h4,         3'b110, 32'h0, 1'b1));
    vv.push_back(mk(32'h3000,      3'b000, 32'h0, 1'b1));
    vv.push_back(mk(32'h5,         3'b100, 32'h0, 1'b1));
    vv.push_back(mk(32'h4000,      3'b000, 32'h0, 1'b1));
    vv.push_back(mk(32'h8000_0004, 3'b011, 32'h0, 1'b1));
    vv.push_back(mk(32'h4,         3'b111, 32'h0, 1'b1));
    rd0 = rd_seen;
    foreach (vv[i]) begin
      issue(vv[i].addr, vv[i].op, vv[i].data, vv[i].err);
      drain();
    end
    chk("err_no_rd", 32'(rd_seen), 32'(rd0));

    // Consumer stall.
    rsp_ready = 1'b0;
    issue(32'h4, 3'b000, 32'h8081_7F02, 1'b0);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_data", rsp_data, 32'h8081_7F02);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("release_req_ready", {31'd0, req_ready}, 32'd1);
    chk("release_valid", {31'd0, rsp_valid}, 32'd0);

    // Reset while in READ.
    issue(32'h5, 3'b001, 32'h0000_007F, 1'b0);
    chk("in_read", {31'd0, mem_rd_en}, 32'd1);
    reset = 1'b1;
    step();
    chk_reset_vals("rst_read");
    reset = 1'b0;
    exp_q.delete();
    quiet_after_reset("rst_read");

    // Reset while stalled in RESP, colliding with rsp_ready.
    rsp_ready = 1'b0;
    issue(32'h6, 3'b010, 32'hFFFF_8081, 1'b0);
    wait_rsp();
    reset     = 1'b1;
    rsp_ready = 1'b1;
    step();
    chk_reset_vals("rst_resp");
    reset = 1'b0;
    exp_q.delete();
    quiet_after_reset("rst_resp");

    // Reset colliding with a request.
    reset     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h4;
    req_op    = 3'b000;
    step();
    chk_reset_vals("rst_req");
    reset     = 1'b0;
    req_valid = 1'b0;
    quiet_after_reset("rst_req");

    // Normal operation still works after resets.
    issue(32'h7, 3'b011, 32'h0000_0080, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, want $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
